// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer arbiter bus: the two host write requesters and the single-port RAM.
//   req_a/req_b       host write request, held until granted
//   addr_a/addr_b     host write address, stable while request high
//   wdata_a/wdata_b   host write data, stable while request high
//   gnt_a/gnt_b       one-cycle grant, the write happens in that cycle
//   mem_addr/mem_we/mem_wdata  RAM command
//   mem_rdata         RAM read data, valid the cycle after the read address
// master: the arbiter side. slave: hosts plus RAM.
interface vga_fb_arbiter_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 8
);
    logic              req_a;
    logic              req_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_a;
    logic              gnt_b;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_a, req_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata,
        output gnt_a, gnt_b, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output req_a, req_b, addr_a, addr_b, wdata_a, wdata_b, mem_rdata,
        input  gnt_a, gnt_b, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer scheduler. Every active pixel (disp_ena) gets a display
// read; blanking cycles are offered to two host writers in round-robin order. With
// wr_mode=1 hosts may only write during vertical blanking (tear-free).
//   clk, rst        clock and synchronous active-low reset
//   disp_ena/col/row  scan position from the VGA timing generator
//   wr_mode         0: write in any blank cycle, 1: vertical blanking only
//   bus             host requests/grants and RAM command/read data (master side)
//   pix_data/pix_valid  fetched pixel, two cycles after its read address
module vga_fb_arbiter #(
    parameter int unsigned H_PIXELS = 600,
    parameter int unsigned V_PIXELS = 300,
    parameter int unsigned H_BITS   = 10,
    parameter int unsigned V_BITS   = 9,
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_ena,
    input  logic [H_BITS-1:0] col,
    input  logic [V_BITS-1:0] row,
    input  logic              wr_mode,
    vga_fb_arbiter_if.master  bus,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);
    // Wide enough for row*H_PIXELS+col without overflow; truncated to ADDR_W afterwards.
    localparam int unsigned FULL_W = V_BITS + H_BITS + $clog2(H_PIXELS + 1);
    localparam logic [H_BITS-1:0] LAST_COL = H_BITS'(H_PIXELS - 1);
    localparam logic [V_BITS-1:0] LAST_ROW = V_BITS'(V_PIXELS - 1);

    typedef enum logic {StVblank, StActive} win_e;

    win_e win_q;
    logic rr_q;  // 0 favours host A when both request
    logic rd_q;  // display read issued last cycle

    logic [FULL_W-1:0] rd_addr_full;
    logic              wr_ok;
    logic              host_slot;
    logic              sel_b;

    always_comb begin
        rd_addr_full = FULL_W'(row) * FULL_W'(H_PIXELS) + FULL_W'(col);
        wr_ok        = !wr_mode || (win_q == StVblank);
        // Reset gates every command so the RAM sees an idle cycle while rst is low.
        host_slot    = rst && !disp_ena && wr_ok && (bus.req_a || bus.req_b);
        sel_b        = bus.req_b && (!bus.req_a || rr_q);

        bus.gnt_a     = host_slot && !sel_b;
        bus.gnt_b     = host_slot && sel_b;
        bus.mem_we    = host_slot;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (rst && disp_ena) begin
            bus.mem_addr = ADDR_W'(rd_addr_full);
        end else if (host_slot) begin
            bus.mem_addr  = sel_b ? bus.addr_b : bus.addr_a;
            bus.mem_wdata = sel_b ? bus.wdata_b : bus.wdata_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q     <= StVblank;
            rr_q      <= 1'b0;
            rd_q      <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            rd_q      <= disp_ena;
            pix_valid <= rd_q;
            if (rd_q) begin
                pix_data <= bus.mem_rdata;
            end
            if (host_slot) begin
                rr_q <= !sel_b;  // point at the host that was not served
            end
            case (win_q)
                StVblank: begin
                    if (disp_ena && row == '0 && col == '0) begin
                        win_q <= StActive;
                    end
                end
                StActive: begin
                    // Leave after the last visible pixel of the frame has been read.
                    if (disp_ena && row == LAST_ROW && col == LAST_COL) begin
                        win_q <= StVblank;
                    end
                end
                default: win_q <= StVblank;
            endcase
        end
    end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Schedules the single-port pixel framebuffer shared between the VGA scan-out path and two host write requesters. Sits between the VGA timing generator (consumes its `disp_ena`/`col`/`row`) and the framebuffer RAM. It guarantees one display read per active pixel and fills blanking cycles with round-robin host writes. An optional tear-free mode restricts host writes to vertical blanking.

## Interface

Parameters:
- `H_PIXELS`, 600, active pixels per line
- `V_PIXELS`, 300, active lines per frame
- `H_BITS`, 10, width of `col`
- `V_BITS`, 9, width of `row`
- `ADDR_W`, 18, framebuffer address width (must hold `H_PIXELS*V_PIXELS-1`)
- `DATA_W`, 8, pixel width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-low reset (`rst==0` resets on the clock edge)
- `disp_ena`  in  1  active-pixel flag from timing generator
- `col`  in  H_BITS  current pixel column
- `row`  in  V_BITS  current pixel row
- `wr_mode`  in  1  0: hosts write in any blank cycle; 1: vertical blanking only
- `req_a`, `req_b`  in  1  host write request, held until granted
- `addr_a`, `addr_b`  in  ADDR_W  host write address, stable while req high
- `wdata_a`, `wdata_b`  in  DATA_W  host write data, stable while req high
- `gnt_a`, `gnt_b`  out  1  one-cycle grant; write is performed in that cycle
- `mem_addr`  out  ADDR_W  RAM address
- `mem_we`  out  1  RAM write enable
- `mem_wdata`  out  DATA_W  RAM write data
- `mem_rdata`  in  DATA_W  RAM read data, valid the cycle after the read address
- `pix_data`  out  DATA_W  fetched pixel
- `pix_valid`  out  1  `pix_data` valid

## Operation

- Per-cycle slot decision, by priority:
  1. `disp_ena==1`: display read. `mem_we=0`, `mem_addr=row*H_PIXELS+col`, computed at full precision and truncated to ADDR_W.
  2. Host slot, when `disp_ena==0`, write permitted, and either request is high.
  3. Otherwise idle: `mem_we=0`, `mem_addr=0`.
- Host slot:
  - Grant one requester: `mem_we=1`, with `mem_addr`/`mem_wdata` taken from the granted host, and that host's `gnt` high.
  - `mem_addr`, `mem_we`, `mem_wdata`, `gnt_*` are combinational from the current inputs and registered state.
- Round-robin:
  - 1-bit pointer `rr`; reset value selects A.
  - Only one requester high: that requester is granted.
  - Both high: grant the host selected by `rr`.
  - After any grant, `rr` points to the other host.
- Window FSM, states VBLANK and ACTIVE:
  - Reset state is VBLANK.
  - VBLANK -> ACTIVE on a cycle with `disp_ena==1`, `row==0`, `col==0`.
  - ACTIVE -> VBLANK on the cycle after a display read with `row==V_PIXELS-1`, `col==H_PIXELS-1`.
  - ACTIVE holds through horizontal blanking.
- Write permission:
  - `wr_mode==0`: permitted whenever `disp_ena==0`.
  - `wr_mode==1`: permitted only in VBLANK.
  - `wr_mode` is sampled every cycle; changing it mid-frame takes effect the same cycle.
- Pixel pipeline:
  - A display read in cycle t registers `mem_rdata` into `pix_data` at the end of t+1.
  - `pix_valid` is the display-read flag delayed 2 cycles.
  - `pix_data` holds its value when `pix_valid==0`.
- Boundary behaviour:
  - A request arriving in the same cycle `disp_ena` rises is not granted.
  - A write granted in the cycle before `disp_ena` rises completes normally.
  - `col`/`row` outside the active range while `disp_ena==1` still produce a read at the computed address; there is no clamping.

## Timing

- Display read latency is 2 cycles: address at t, `pix_valid`/`pix_data` at t+2. Throughput is 1 pixel/cycle.
- Host grant latency is 0 cycles from the first eligible cycle.
- Worst-case wait:
  - With `wr_mode==0`: one active line plus one host slot.
  - With `wr_mode==1`: one full frame plus one host slot.
- Reset (`rst==0` at an edge):
  - `pix_valid=0`, `pix_data=0`, `rr`=A, FSM=VBLANK, pipeline flags cleared.
  - During the reset cycle: `gnt_a=gnt_b=0`, `mem_we=0`, `mem_addr=0`.
- Reset mid-line discards in-flight pixels; `pix_valid` stays 0 for the 2 cycles following release.
- Reset has no effect on host-held requests; they are re-arbitrated after release.

## Test plan

- Reset: hold `rst=0` 3 cycles with `req_a=1` and `disp_ena=1` -> `gnt_a=0`, `mem_we=0`, `pix_valid=0`, `pix_data=0`. After release, the first grant with both requesting goes to A.
- Display fetch: `disp_ena=1`, `row=2`, `col=5` at cycle t -> `mem_addr=1205`, `mem_we=0`. `mem_rdata=0x5A` at t+1 -> `pix_data=0x5A`, `pix_valid=1` at t+2. Corner `row=299`, `col=599` -> `mem_addr=179999`.
- Round-robin: `wr_mode=0`, `disp_ena=0`, `req_a=req_b=1` held 4 cycles -> grants A, B, A, B. Each grant drives `mem_addr`/`mem_wdata` of the granted host with `mem_we=1`.
- Priority: `req_b=1` while `disp_ena=1` for 600 cycles -> no `gnt_b`. `gnt_b=1` in the first cycle `disp_ena` falls.
- Tear-free: `wr_mode=1`, `req_a=1` during horizontal blanking of row 10 -> no grant. After the read at `row=299`, `col=599` -> `gnt_a` in the next cycle. No grant after `disp_ena` rises at `row=0`, `col=0`.
- Reset mid-operation: assert `rst=0` one cycle after a display read -> `pix_valid` stays 0 through t+2; FSM returns to VBLANK, verified by a `wr_mode=1` grant while `disp_ena=0`.
